odometer_seq_ctrl: RTL
======================

ODOMETER_SEQ_CTRL -- requirements
Module: odometer_seq_ctrl

Interface
REQ-001 SHALL have parameter STRESS_W, default 16, width of the stress-duration counter.
REQ-002 SHALL have parameter MEAS_W, default 8, width of the measurement-window counter.
REQ-003 SHALL have port CLK  input  1  sequencer clock, rising edge.
REQ-004 SHALL have port RESETB  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port GO  input  1  start-run request, sampled in IDLE.
REQ-006 SHALL have port ABORT  input  1  terminate run.
REQ-007 SHALL have port TYPE_MASK  input  3  rosc types to run: bit0 INV, bit1 NAND, bit2 NOR.
REQ-008 SHALL have port AC_MODE  input  1  stress mode, 1 = AC, 0 = DC.
REQ-009 SHALL have port STRESS_CYC  input  STRESS_W  stress duration in CLK cycles.
REQ-010 SHALL have port MEAS_CYC  input  MEAS_W  beat-frequency window in CLK cycles.
REQ-011 SHALL have port BF_COUNT  input  12  odometer beat count.
REQ-012 SHALL have ports LOAD, SEL_INV, SEL_NAND, SEL_NOR, START, AC_DC, MEAS_TRIG  output  1 each  odometer controls.
REQ-013 SHALL have port BUSY  output  1  run in progress.
REQ-014 SHALL have port DONE  output  1  one-cycle end-of-run pulse.
REQ-015 SHALL have ports RES_VALID output 1, RES_READY input 1, RES_DATA output 14 = {type[1:0], count[11:0]}; type 0 INV, 1 NAND, 2 NOR.
REQ-016 SHALL have port OVERRUN  output  1  sticky result-dropped flag.

Function
REQ-017 FSM states: IDLE, LOAD, STRESS, TRIG, MEAS, CAPT, HOLD, NEXT.
REQ-018 IDLE: GO=1 with TYPE_MASK!=0 -> latch TYPE_MASK, AC_MODE, STRESS_CYC, MEAS_CYC; go LOAD; GO with mask 0 ignored; later input changes ignored until IDLE.
REQ-019 Type order: lowest set mask bit first, ascending; SEL_x one-hot for current type, held from LOAD through MEAS, 0 elsewhere.
REQ-020 LOAD: LOAD=1 for exactly one cycle, AC_DC=latched AC_MODE; next STRESS.
REQ-021 STRESS: START=1 for exactly STRESS_CYC cycles (0 treated as 1); next TRIG.
REQ-022 TRIG: START=0, MEAS_TRIG=1 for exactly one cycle; next MEAS.
REQ-023 MEAS: wait MEAS_CYC cycles (0 treated as 1); next CAPT.
REQ-024 CAPT: register {type, BF_COUNT} into RES_DATA, RES_VALID=1 from next cycle; go HOLD.
REQ-025 HOLD: RES_VALID and RES_DATA stable until RES_VALID&&RES_READY; on handshake RES_VALID=0, go NEXT.
REQ-026 NEXT: remaining mask bits -> LOAD with next type; none -> IDLE with DONE=1 for one cycle.
REQ-027 BUSY=1 in every state except IDLE; GO while BUSY ignored.
REQ-028 ABORT=1 in any state: next cycle IDLE, all odometer controls 0, RES_VALID 0, no DONE; ABORT wins over simultaneous GO or RES_READY.
REQ-029 Counters SHALL not wrap: all-ones STRESS_CYC/MEAS_CYC gives exactly 2^W-1 cycles.

Reset
REQ-030 RESETB=0 SHALL asynchronously force IDLE and all outputs 0 (RES_DATA 0, OVERRUN 0), including mid-run; no DONE on reset exit.

Configuration
REQ-031 Macro ODOMETER_SEQ_TIMEOUT_EN defined: HOLD lasting 256 cycles without handshake drops result, RES_VALID=0, OVERRUN=1 (sticky until reset or next accepted GO), go NEXT.
REQ-032 Macro undefined: HOLD waits indefinitely; OVERRUN constant 0.

Verification
REQ-033 MASK=3'b111, STRESS_CYC=4, MEAS_CYC=3, RES_READY=1 -> three results, types 0,1,2, START 4 cycles each, one MEAS_TRIG per type, DONE once.
REQ-034 MASK=3'b100, BF_COUNT=12'hABC during CAPT -> RES_DATA=14'h2ABC, SEL_NOR only selector set.
REQ-035 STRESS_CYC=0, MEAS_CYC=0 -> START 1 cycle, MEAS 1 cycle, run completes.
REQ-036 RES_READY=0 for 10 cycles in HOLD -> RES_DATA stable, RES_VALID held; with macro and 300 cycles -> OVERRUN=1, run proceeds.
REQ-037 ABORT during STRESS -> next cycle BUSY=0, START=0, no DONE; new GO restarts from lowest type.
REQ-038 RESETB low during MEAS -> outputs 0 immediately, before next CLK edge.

Source files
------------

// File: rtl/odometer_seq_ctrl.sv
// Odometer stress/measure sequencer: runs LOAD-STRESS-TRIG-MEAS-CAPT-HOLD per selected rosc type.
// Optional macro ODOMETER_SEQ_TIMEOUT_EN enables the HOLD timeout that drops a result and sets OVERRUN.
module odometer_seq_ctrl #(
  parameter int unsigned STRESS_W = 16,
  parameter int unsigned MEAS_W   = 8
) (
  input  logic                CLK,
  input  logic                RESETB,
  input  logic                GO,
  input  logic                ABORT,
  input  logic [2:0]          TYPE_MASK,
  input  logic                AC_MODE,
  input  logic [STRESS_W-1:0] STRESS_CYC,
  input  logic [MEAS_W-1:0]   MEAS_CYC,
  input  logic [11:0]         BF_COUNT,
  output logic                LOAD,
  output logic                SEL_INV,
  output logic                SEL_NAND,
  output logic                SEL_NOR,
  output logic                START,
  output logic                AC_DC,
  output logic                MEAS_TRIG,
  output logic                BUSY,
  output logic                DONE,
  output logic                RES_VALID,
  input  logic                RES_READY,
  output logic [13:0]         RES_DATA,
  output logic                OVERRUN
);

  localparam int unsigned CNT_W  = (STRESS_W > MEAS_W) ? STRESS_W : MEAS_W;
  localparam int unsigned HOLD_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STRESS,
    ST_TRIG,
    ST_MEAS,
    ST_CAPT,
    ST_HOLD,
    ST_NEXT
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          cur_q, cur_d;
  logic [2:0]          rem_q, rem_d;
  logic                ac_mode_q, ac_mode_d;
  logic [STRESS_W-1:0] stress_q, stress_d;
  logic [MEAS_W-1:0]   meas_q, meas_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                load_q, load_d;
  logic [2:0]          sel_q, sel_d;
  logic                start_q, start_d;
  logic                ac_dc_q, ac_dc_d;
  logic                meas_trig_q, meas_trig_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                res_valid_q, res_valid_d;
  logic [13:0]         res_data_q, res_data_d;
  logic                overrun_q, overrun_d;
  logic                run_sel;

`ifdef ODOMETER_SEQ_TIMEOUT_EN
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
`endif

  // Index of the lowest set mask bit; types run in ascending order.
  function automatic logic [1:0] low_idx(input logic [2:0] m);
    if (m[0])      low_idx = 2'd0;
    else if (m[1]) low_idx = 2'd1;
    else           low_idx = 2'd2;
  endfunction

  function automatic logic [2:0] type_onehot(input logic [1:0] t);
    type_onehot = 3'(3'b001 << t);
  endfunction

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    rem_d       = rem_q;
    ac_mode_d   = ac_mode_q;
    stress_d    = stress_q;
    meas_d      = meas_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    overrun_d   = overrun_q;
    done_d      = 1'b0;
`ifdef ODOMETER_SEQ_TIMEOUT_EN
    hold_cnt_d  = hold_cnt_q;
`endif

    if (ABORT) begin
      state_d     = ST_IDLE;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (GO && (TYPE_MASK != 3'b000)) begin
            ac_mode_d = AC_MODE;
            stress_d  = STRESS_CYC;
            meas_d    = MEAS_CYC;
            cur_d     = low_idx(TYPE_MASK);
            rem_d     = TYPE_MASK & ~type_onehot(low_idx(TYPE_MASK));
            overrun_d = 1'b0;
            state_d   = ST_LOAD;
          end
        end
        // Zero-length stress/measure requests are stretched to one cycle.
        ST_LOAD: begin
          cnt_d   = (stress_q == '0) ? CNT_W'(1) : CNT_W'(stress_q);
          state_d = ST_STRESS;
        end
        ST_STRESS: begin
          if (cnt_q == CNT_W'(1)) state_d = ST_TRIG;
          else                    cnt_d   = cnt_q - CNT_W'(1);
        end
        ST_TRIG: begin
          cnt_d   = (meas_q == '0) ? CNT_W'(1) : CNT_W'(meas_q);
          state_d = ST_MEAS;
        end
        ST_MEAS: begin
          if (cnt_q == CNT_W'(1)) state_d = ST_CAPT;
          else                    cnt_d   = cnt_q - CNT_W'(1);
        end
        ST_CAPT: begin
          res_data_d  = {cur_q, BF_COUNT};
          res_valid_d = 1'b1;
          state_d     = ST_HOLD;
`ifdef ODOMETER_SEQ_TIMEOUT_EN
          hold_cnt_d  = '0;
`endif
        end
        ST_HOLD: begin
          if (res_valid_q && RES_READY) begin
            res_valid_d = 1'b0;
            state_d     = ST_NEXT;
          end
`ifdef ODOMETER_SEQ_TIMEOUT_EN
          // 256th unacknowledged HOLD cycle: drop the result and move on.
          else if (hold_cnt_q == '1) begin
            res_valid_d = 1'b0;
            overrun_d   = 1'b1;
            state_d     = ST_NEXT;
          end else begin
            hold_cnt_d  = hold_cnt_q + HOLD_W'(1);
          end
`endif
        end
        ST_NEXT: begin
          if (rem_q != 3'b000) begin
            cur_d   = low_idx(rem_q);
            rem_d   = rem_q & ~type_onehot(low_idx(rem_q));
            state_d = ST_LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Controls are decoded from the next state so they line up with the registered state.
    run_sel     = (state_d == ST_LOAD) || (state_d == ST_STRESS) ||
                  (state_d == ST_TRIG) || (state_d == ST_MEAS);
    sel_d       = run_sel ? type_onehot(cur_d) : 3'b000;
    load_d      = (state_d == ST_LOAD);
    start_d     = (state_d == ST_STRESS);
    meas_trig_d = (state_d == ST_TRIG);
    ac_dc_d     = run_sel && ac_mode_d;
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q     <= ST_IDLE;
      cur_q       <= 2'd0;
      rem_q       <= 3'b000;
      ac_mode_q   <= 1'b0;
      stress_q    <= '0;
      meas_q      <= '0;
      cnt_q       <= '0;
      load_q      <= 1'b0;
      sel_q       <= 3'b000;
      start_q     <= 1'b0;
      ac_dc_q     <= 1'b0;
      meas_trig_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= 14'd0;
      overrun_q   <= 1'b0;
`ifdef ODOMETER_SEQ_TIMEOUT_EN
      hold_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      rem_q       <= rem_d;
      ac_mode_q   <= ac_mode_d;
      stress_q    <= stress_d;
      meas_q      <= meas_d;
      cnt_q       <= cnt_d;
      load_q      <= load_d;
      sel_q       <= sel_d;
      start_q     <= start_d;
      ac_dc_q     <= ac_dc_d;
      meas_trig_q <= meas_trig_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      overrun_q   <= overrun_d;
`ifdef ODOMETER_SEQ_TIMEOUT_EN
      hold_cnt_q  <= hold_cnt_d;
`endif
    end
  end

  assign LOAD      = load_q;
  assign SEL_INV   = sel_q[0];
  assign SEL_NAND  = sel_q[1];
  assign SEL_NOR   = sel_q[2];
  assign START     = start_q;
  assign AC_DC     = ac_dc_q;
  assign MEAS_TRIG = meas_trig_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign RES_VALID = res_valid_q;
  assign RES_DATA  = res_data_q;
  assign OVERRUN   = overrun_q;

endmodule
